// File: rtl/fifo_width_serializer_pkg.sv
// Shared constants and FSM state type for the FIFO width serializer.
// The serializer slices wide FIFO words into narrow output beats.
package fifo_width_serializer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int OUT_WIDTH  = 8;
  localparam int PKT_WORDS  = 4;
  localparam int NUM_BEATS  = DATA_WIDTH / OUT_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_width_serializer.sv
// Pops words from an upstream FWFT FIFO and streams them as LSB-first beats.
// Words are grouped into packets of PKT_WORDS words, and m_last_o marks the final beat of each packet.
module fifo_width_serializer #(
  parameter int DATA_WIDTH = fifo_width_serializer_pkg::DATA_WIDTH,
  parameter int OUT_WIDTH  = fifo_width_serializer_pkg::OUT_WIDTH,
  parameter int PKT_WORDS  = fifo_width_serializer_pkg::PKT_WORDS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  output logic [OUT_WIDTH-1:0]  m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o
);
  import fifo_width_serializer_pkg::*;

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WCW   = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(PKT_WORDS - 1);

  if (((DATA_WIDTH % OUT_WIDTH) != 0) || (BEATS < 2)) begin : g_badParams
    $error("fifo_width_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
  end

  state_e                r_state;
  state_e                w_nextState;
  logic [DATA_WIDTH-1:0] r_shiftReg;
  logic [BCW-1:0]        r_beatCnt;
  logic [WCW-1:0]        r_wordCnt;
  logic                  w_xfer;
  logic                  w_lastBeat;
  logic                  w_wordDone;
  logic                  w_pop;

  assign w_xfer     = (r_state == SEND) && m_ready_i;
  assign w_lastBeat = (r_beatCnt == LAST_BEAT);
  assign w_wordDone = w_xfer && w_lastBeat;

  // Pop when idle, or back-to-back on the final beat so the stream has no bubble.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!fifo_empty_i) begin
          w_pop       = 1'b1;
          w_nextState = SEND;
        end
      end
      SEND: begin
        if (w_wordDone) begin
          if (!fifo_empty_i) begin
            w_pop = 1'b1;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_shiftReg <= '0;
      r_beatCnt  <= '0;
      r_wordCnt  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_pop) begin
        r_shiftReg <= fifo_data_i;
        r_beatCnt  <= '0;
      end else if (w_xfer) begin
        r_shiftReg <= r_shiftReg >> OUT_WIDTH;
        r_beatCnt  <= w_lastBeat ? '0 : r_beatCnt + 1'b1;
      end
      if (w_wordDone) begin
        r_wordCnt <= (r_wordCnt == LAST_WORD) ? '0 : r_wordCnt + 1'b1;
      end
    end
  end

  // The pop strobe is gated by reset so nothing is lost while the block is held in reset.
  assign fifo_rd_en_o = w_pop && rst_ni;
  assign m_data_o     = r_shiftReg[OUT_WIDTH-1:0];
  assign m_valid_o    = (r_state == SEND);
  assign busy_o       = (r_state == SEND);
  assign m_last_o     = (r_state == SEND) && w_lastBeat && (r_wordCnt == LAST_WORD);

endmodule
